// File: rtl/scan_clkgen_pkg.sv
// Shared types and defaults for the two-phase non-overlapping scan clock generator.
package scan_clkgen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PH_P   = 3'd1,
    GAP_PN = 3'd2,
    PH_N   = 3'd3,
    GAP_NP = 3'd4
  } state_t;

  localparam int unsigned DEF_HIGH_TICKS  = 1;
  localparam int unsigned DEF_GAP_TICKS   = 1;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_sync.sv
// Multi-flop asynchronous-reset synchronizer for a single level signal.
module scan_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [Stages-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= {r_q[Stages-2:0], i_d};
    end
  end

  assign o_q = r_q[Stages-1];

endmodule

// File: rtl/scan_clkgen_2ph.sv
// Two-phase non-overlapping scan clock generator; starts/stops only on whole scan cycles.
module scan_clkgen_2ph
  import scan_clkgen_pkg::*;
#(
  parameter int unsigned HighTicks  = DEF_HIGH_TICKS,
  parameter int unsigned GapTicks   = DEF_GAP_TICKS,
  parameter int unsigned SyncStages = DEF_SYNC_STAGES
) (
  input  logic i_clk_ref,
  input  logic i_rstb,
  input  logic i_clk_en,
  output logic o_sclkp,
  output logic o_sclkn,
  output logic o_busy,
  output logic o_cycle_done
);

  localparam int unsigned CntMax = max_u(HighTicks, GapTicks);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HighLast = CntW'(HighTicks - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GapTicks - 1);

  if (HighTicks < 1 || GapTicks < 1 || SyncStages < 2) begin : g_bad_params
    $error("scan_clkgen_2ph: HighTicks>=1, GapTicks>=1, SyncStages>=2 required");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            w_en_s;
  logic            w_last;
  logic            w_done_nxt;
  logic            r_sclkp;
  logic            r_sclkn;
  logic            r_busy;
  logic            r_done;

  scan_sync #(
    .Stages(SyncStages)
  ) u_sync (
    .i_clk  (i_clk_ref),
    .i_rst_n(i_rstb),
    .i_d    (i_clk_en),
    .o_q    (w_en_s)
  );

  always_ff @(posedge i_clk_ref or negedge i_rstb) begin
    if (!i_rstb) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Enable is only consulted in IDLE and at the end of GAP_NP, so a cycle always completes.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_en_s) w_state_nxt = PH_P;
      end
      PH_P: begin
        w_last = (r_cnt == HighLast);
        if (w_last) w_state_nxt = GAP_PN;
      end
      GAP_PN: begin
        w_last = (r_cnt == GapLast);
        if (w_last) w_state_nxt = PH_N;
      end
      PH_N: begin
        w_last = (r_cnt == HighLast);
        if (w_last) w_state_nxt = GAP_NP;
      end
      GAP_NP: begin
        w_last = (r_cnt == GapLast);
        if (w_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = w_en_s ? PH_P : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt != r_state || r_state == IDLE) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Outputs decoded from next state so they switch on the same edge as the state.
  always_ff @(posedge i_clk_ref or negedge i_rstb) begin
    if (!i_rstb) begin
      r_sclkp <= 1'b0;
      r_sclkn <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sclkp <= (w_state_nxt == PH_P);
      r_sclkn <= (w_state_nxt == PH_N);
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign o_sclkp      = r_sclkp;
  assign o_sclkn      = r_sclkn;
  assign o_busy       = r_busy;
  assign o_cycle_done = r_done;

endmodule

// File: tb/tb_scan_clkgen_2ph.sv
// Scoreboard bench for scan_clkgen_2ph: default and HighTicks=3/GapTicks=2 instances.
module tb_scan_clkgen_2ph;

  logic clk;
  logic rstb;
  logic en;
  logic p0, n0, b0, d0;
  logic p1, n1, b1, d1;

  int n_tests = 0;
  int n_fail  = 0;

  scan_clkgen_2ph dut_dflt (
    .i_clk_ref   (clk),
    .i_rstb      (rstb),
    .i_clk_en    (en),
    .o_sclkp     (p0),
    .o_sclkn     (n0),
    .o_busy      (b0),
    .o_cycle_done(d0)
  );

  scan_clkgen_2ph #(
    .HighTicks(3),
    .GapTicks (2)
  ) dut_h3g2 (
    .i_clk_ref   (clk),
    .i_rstb      (rstb),
    .i_clk_en    (en),
    .o_sclkp     (p1),
    .o_sclkn     (n1),
    .o_busy      (b1),
    .o_cycle_done(d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Position-in-period reference model: 2-deep enable pipe, active flag, cycle position.
  typedef struct packed {
    logic [1:0]  sync;
    logic        active;
    int unsigned pos;
    logic        done;
  } mdl_t;

  function automatic mdl_t mdl_step(input mdl_t m, input logic e, input int unsigned h,
                                    input int unsigned g);
    mdl_t r;
    int unsigned per;
    per    = 2 * (h + g);
    r      = m;
    r.done = 1'b0;
    if (!m.active) begin
      if (m.sync[1]) begin
        r.active = 1'b1;
        r.pos    = 0;
      end
    end else if (m.pos == per - 1) begin
      r.done = 1'b1;
      if (m.sync[1]) r.pos = 0;
      else r.active = 1'b0;
    end else begin
      r.pos = m.pos + 1;
    end
    r.sync = {m.sync[0], e};
    return r;
  endfunction

  function automatic logic [3:0] mdl_out(input mdl_t m, input int unsigned h, input int unsigned g);
    logic p, n;
    p = m.active && (m.pos < h);
    n = m.active && (m.pos >= h + g) && (m.pos < 2 * h + g);
    return {p, n, m.active, m.done};
  endfunction

  mdl_t       m0, m1;
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      m0 = '0;
      m1 = '0;
      q0.delete();
      q1.delete();
    end else begin
      m0 = mdl_step(m0, en, 1, 1);
      m1 = mdl_step(m1, en, 3, 2);
      q0.push_back(mdl_out(m0, 1, 1));
      q1.push_back(mdl_out(m1, 3, 2));
    end
  end

  always @(negedge clk) begin
    if (q0.size() > 0) check_eq("sb_dflt", {p0, n0, b0, d0}, q0.pop_front());
    else if (!rstb) check_eq("rst_dflt", {p0, n0, b0, d0}, 4'b0000);
    if (q1.size() > 0) check_eq("sb_h3g2", {p1, n1, b1, d1}, q1.pop_front());
    else if (!rstb) check_eq("rst_h3g2", {p1, n1, b1, d1}, 4'b0000);
    check_eq("overlap_dflt", p0 & n0, 1'b0);
    check_eq("overlap_h3g2", p1 & n1, 1'b0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int k;
  int cp0, cn0, cd0, cp1, cn1, cd1;
  logic [7:0] pv8, nv8, dv8;
  logic [9:0] pv10, nv10, dv10;
  logic       ball;

  initial begin
    rstb = 1'b0;
    en   = 1'b1;
    repeat (3) tick();
    check_eq("rst_sclkp", p0, 1'b0);
    check_eq("rst_sclkn", n0, 1'b0);
    check_eq("rst_busy", b0, 1'b0);
    check_eq("rst_done", d0, 1'b0);

    rstb = 1'b1;
    k = 0;
    tick();
    while (!p0 && k < 20) begin
      k++;
      tick();
    end
    check_eq("latency", k, 2);
    repeat (16) tick();

    k = 0;
    while (!p0 && k < 10) begin
      k++;
      tick();
    end
    check_eq("drop_find_p", p0, 1'b1);
    en  = 1'b0;
    cp0 = 0; cn0 = 0; cd0 = 0;
    repeat (12) begin
      tick();
      cp0 += int'(p0);
      cn0 += int'(n0);
      cd0 += int'(d0);
    end
    check_eq("drop_p_cnt", cp0, 0);
    check_eq("drop_n_cnt", cn0, 1);
    check_eq("drop_done_cnt", cd0, 1);
    check_eq("drop_busy", b0, 1'b0);

    en = 1'b1;
    k  = 0;
    tick();
    while (!n0 && k < 30) begin
      k++;
      tick();
    end
    check_eq("find_n", n0, 1'b1);
    #2 rstb = 1'b0;
    #1;
    check_eq("async_rst_sclkn", n0, 1'b0);
    check_eq("async_rst_sclkp", p0, 1'b0);
    check_eq("async_rst_busy", b0, 1'b0);
    tick();
    tick();
    rstb = 1'b1;
    k = 0;
    tick();
    while (!(p0 | n0) && k < 20) begin
      k++;
      tick();
    end
    check_eq("restart_p_first", {p0, n0}, 2'b10);
    check_eq("restart_latency", k, 2);

    ball = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      pv8[7-i] = p0;
      nv8[7-i] = n0;
      dv8[7-i] = d0;
      ball     = ball & b0;
    end
    check_eq("dflt_p_pattern", pv8, 8'b00010001);
    check_eq("dflt_n_pattern", nv8, 8'b01000100);
    check_eq("dflt_done_pattern", dv8, 8'b00010001);
    check_eq("dflt_busy_held", ball, 1'b1);

    k = 0;
    while (p1 && k < 30) begin
      k++;
      tick();
    end
    check_eq("h3g2_find_low", p1, 1'b0);
    k = 0;
    while (!p1 && k < 30) begin
      k++;
      tick();
    end
    check_eq("h3g2_find_rise", p1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      pv10[9-i] = p1;
      nv10[9-i] = n1;
      dv10[9-i] = d1;
    end
    check_eq("h3g2_p_pattern", pv10, 10'b1110000000);
    check_eq("h3g2_n_pattern", nv10, 10'b0000011100);
    check_eq("h3g2_done_pattern", dv10, 10'b1000000000);

    en = 1'b0;
    repeat (20) tick();
    check_eq("idle_busy_dflt", b0, 1'b0);
    check_eq("idle_busy_h3g2", b1, 1'b0);
    en = 1'b1;
    tick();
    en  = 1'b0;
    cp0 = 0; cn0 = 0; cd0 = 0;
    cp1 = 0; cn1 = 0; cd1 = 0;
    repeat (25) begin
      tick();
      cp0 += int'(p0);
      cn0 += int'(n0);
      cd0 += int'(d0);
      cp1 += int'(p1);
      cn1 += int'(n1);
      cd1 += int'(d1);
    end
    check_eq("pulse_p_dflt", cp0, 1);
    check_eq("pulse_n_dflt", cn0, 1);
    check_eq("pulse_done_dflt", cd0, 1);
    check_eq("pulse_busy_dflt", b0, 1'b0);
    check_eq("pulse_p_h3g2", cp1, 3);
    check_eq("pulse_n_h3g2", cn1, 3);
    check_eq("pulse_done_h3g2", cd1, 1);
    check_eq("pulse_busy_h3g2", b1, 1'b0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_clkgen_2ph.md
Name: scan_clkgen_2ph

Overview:
Two-phase, non-overlapping scan clock generator. It derives the scan-chain clocks o_sclkp/o_sclkn from a free-running reference clock, under control of an enable. It sits between the bench/chip clock source and the scan chain of the DSP front end (scan sclkp/sclkn inputs). Starts and stops only on whole scan-cycle boundaries, so no truncated or overlapping pulses ever appear.

Parameters:
HighTicks, 1, reference cycles each phase pulse (o_sclkp or o_sclkn) stays high; must be >= 1
GapTicks, 1, reference cycles of non-overlap gap after each pulse; must be >= 1
SyncStages, 2, flops in the i_clk_en synchronizer; must be >= 2
Scan period = 2*(HighTicks+GapTicks) reference cycles; the defaults give 4.

Ports:
i_clk_ref  input  1  reference clock; all logic on its rising edge
i_rstb  input  1  asynchronous active-low reset
i_clk_en  input  1  scan clock enable; asynchronous to i_clk_ref, level-sensitive
o_sclkp  output  1  scan clock phase P (first pulse of a cycle), registered
o_sclkn  output  1  scan clock phase N (second pulse of a cycle), registered
o_busy  output  1  high while a scan cycle is in progress (state != IDLE)
o_cycle_done  output  1  one-reference-cycle pulse at completion of each full scan cycle

Interface: one clock (i_clk_ref); reset (i_rstb) is asynchronous and active-low.

Behaviour:
- Reset (i_rstb=0, asynchronous): o_sclkp=0, o_sclkn=0, o_busy=0, o_cycle_done=0; synchronizer cleared; FSM=IDLE; tick counter=0. Reset asserted mid-cycle drops both clocks immediately. After release, the block waits for a fresh synchronized enable.
- Enable synchronizer: i_clk_en passes through SyncStages flops; en_s is the last stage.
- FSM states: IDLE, PH_P, GAP_PN, PH_N, GAP_NP. A tick counter counts the cycles spent in the current state.
- Transitions:
  - IDLE -> PH_P when en_s=1.
  - PH_P -> GAP_PN after HighTicks cycles.
  - GAP_PN -> PH_N after GapTicks cycles.
  - PH_N -> GAP_NP after HighTicks cycles.
  - GAP_NP ends after GapTicks cycles: goes to PH_P if en_s=1, else IDLE.
- en_s is examined only in IDLE and at the end of GAP_NP. Deasserting enable mid-cycle always completes the current cycle, including the N pulse and the final gap.
- Outputs are registered from the next-state decode, so they change on the same edge as the state:
  - o_sclkp=1 exactly while in PH_P.
  - o_sclkn=1 exactly while in PH_N.
  - o_busy=1 whenever the state is not IDLE.
- Latency: if i_clk_en is first sampled high at edge 0, o_sclkp is high after edge SyncStages (defaults: after edge 2).
- o_cycle_done is high for the single reference cycle following the edge that leaves GAP_NP.
- Invariant: o_sclkp & o_sclkn is never 1. At least GapTicks low cycles always separate the two pulses.
- Any enable pulse that is caught by the synchronizer yields at least one complete scan cycle.
- Glitch-free: outputs come only from flops, with no combinational path from i_clk_en.
- Counter width: $clog2(max(HighTicks,GapTicks)+1). The counter resets to 0 on every state change.
- Elaboration-time assertion: HighTicks>=1, GapTicks>=1, SyncStages>=2.

Decomposition:
- Package scan_clkgen_pkg: the state enum (IDLE, PH_P, GAP_PN, PH_N, GAP_NP) and the default tick constants.
- Sub-module scan_sync: a SyncStages-deep async-reset synchronizer, reusable elsewhere.
- Top: FSM, tick counter and output registers.

Test Plan:
- Reset held with i_clk_en=1 -> all outputs 0; after i_rstb release, o_sclkp is high after edge 2.
- Default params with enable held -> o_sclkp = 1,0,0,0 and o_sclkn = 0,0,1,0 repeating (period 4 ref cycles); o_cycle_done pulses every 4 cycles; o_busy stays 1.
- Enable dropped during PH_P -> the N pulse and final gap still occur; then IDLE with o_busy=0 and no further pulses.
- i_rstb asserted during PH_N -> o_sclkn drops to 0 asynchronously before the next ref edge; restart begins with PH_P.
- HighTicks=3, GapTicks=2 -> o_sclkp high 3 cycles, low 2, o_sclkn high 3, low 2; period 10; overlap checker never fires.
- 1-ref-cycle i_clk_en pulse (sampled) -> exactly one complete P/N scan cycle, one o_cycle_done pulse, then IDLE.
